// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
  parameter int FIFO_WIDTH = 8
);
  logic [3:0]              iv_req;
  logic [4*FIFO_WIDTH-1:0] iv_din;
  logic [3:0]              ov_ack;
  logic [3:0]              ov_gnt;
  logic                    o_fifo_wr_en;
  logic [FIFO_WIDTH-1:0]   ov_fifo_din;
  logic                    i_fifo_full;
  logic                    o_busy;

  // Arbiter side
  modport master (
    input  iv_req, iv_din, i_fifo_full,
    output ov_ack, ov_gnt, o_fifo_wr_en, ov_fifo_din, o_busy
  );

  // Requester / FIFO side
  modport slave (
    output iv_req, iv_din, i_fifo_full,
    input  ov_ack, ov_gnt, o_fifo_wr_en, ov_fifo_din, o_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - four-way round-robin burst arbiter onto a single FIFO write port
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_wr_arbiter_if.master   bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner;
  logic [1:0] rr_ptr;
  logic [1:0] pick;
  logic [3:0] cnt;
  logic       accept;
  logic       last_word;

  // First requester at or after ptr, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick      = rr_pick(bus.iv_req, rr_ptr);
  assign accept    = (state == BURST) && bus.iv_req[owner] && !bus.i_fifo_full;
  assign last_word = (cnt == 4'(BURST_LEN - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Owner, round-robin pointer and word counter: loaded on grant, counter steps on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner  <= 2'd0;
      rr_ptr <= 2'd0;
      cnt    <= 4'd0;
    end else if (state == IDLE && |bus.iv_req) begin
      owner  <= pick;
      rr_ptr <= pick + 2'd1;
      cnt    <= 4'd0;
    end else if (accept) begin
      cnt    <= cnt + 4'd1;
    end
  end

  // Next state and outputs; everything is quiet in IDLE, the owner's lane is muxed through in BURST
  always_comb begin
    state_nxt        = state;
    bus.ov_ack       = 4'b0000;
    bus.ov_gnt       = 4'b0000;
    bus.o_fifo_wr_en = 1'b0;
    bus.ov_fifo_din  = '0;
    bus.o_busy       = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.iv_req) state_nxt = BURST;
      end
      BURST: begin
        bus.o_busy       = 1'b1;
        bus.ov_gnt       = 4'b0001 << owner;
        bus.ov_ack       = accept ? (4'b0001 << owner) : 4'b0000;
        bus.o_fifo_wr_en = accept;
        bus.ov_fifo_din  = bus.iv_din[owner*FIFO_WIDTH +: FIFO_WIDTH];
        if (!bus.iv_req[owner])        state_nxt = IDLE;
        else if (accept && last_word)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 8, meaning the data width of each requester and of the FIFO write port.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, range 1..16, meaning the maximum number of words written per grant.
REQ-003 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port iv_req, input, 4 bits: bit k high means requester k holds a valid word.
REQ-006 Port iv_din, input, 4*FIFO_WIDTH bits: requester k data on bits [k*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 Port ov_ack, output, 4 bits: bit k high means requester k's current word is accepted this cycle.
REQ-008 Port ov_gnt, output, 4 bits: one-hot current burst owner; all zero when idle.
REQ-009 Port o_fifo_wr_en, output, 1 bit: write strobe to the async_fifo write port.
REQ-010 Port ov_fifo_din, output, FIFO_WIDTH bits: write data to the FIFO.
REQ-011 Port i_fifo_full, input, 1 bit: FIFO full flag, same clock domain.
REQ-012 Port o_busy, output, 1 bit: high while a burst is owned.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and BURST.
REQ-014 In IDLE with iv_req nonzero, the block SHALL select the first requesting index scanning upward (mod 4) from rr_ptr, register it as owner, load ov_gnt one-hot, and enter BURST on the next edge.
REQ-015 On a grant, rr_ptr SHALL be loaded with owner+1 mod 4.
REQ-016 In IDLE, ov_gnt SHALL be 0, o_busy SHALL be 0, and no write SHALL occur; the grant decision costs exactly one IDLE cycle.
REQ-017 In BURST, o_busy SHALL be 1, and accept = iv_req[owner] & !i_fifo_full.
REQ-018 o_fifo_wr_en and ov_ack[owner] SHALL equal accept combinationally; all other ov_ack bits SHALL be 0.
REQ-019 ov_fifo_din SHALL equal the owner's slice of iv_din combinationally in BURST, and all zeros in IDLE.
REQ-020 A 4-bit word counter SHALL clear on grant and increment on each accept.
REQ-021 The block SHALL return to IDLE on the edge where accept occurs with the counter at BURST_LEN-1.
REQ-022 The block SHALL also return to IDLE on any BURST cycle with iv_req[owner] low, with no write in that cycle.
REQ-023 While i_fifo_full is high in BURST, the block SHALL stall with no write, no counter change and no ack, remain in BURST, and hold the owner.
REQ-024 Requests from non-owners during BURST SHALL be ignored until the next IDLE cycle.
REQ-025 A requester SHALL hold its data stable until acked, and a new word SHALL be presented the cycle after an ack.
REQ-026 Write order to the FIFO SHALL equal per-requester presentation order; no word SHALL be duplicated or dropped.

Reset
REQ-027 While reset_n is low, the block SHALL force state IDLE, rr_ptr=0, owner=0 and counter=0.
REQ-028 While reset_n is low, outputs SHALL be ov_gnt=0, ov_ack=0, o_fifo_wr_en=0, o_busy=0 and ov_fifo_din=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately; after release, arbitration restarts from requester 0.

Verification
REQ-030 Single requester: iv_req=4'b0001 constant with data 0x11,0x12,... and full=0 -> gnt=0001 one cycle after req, four consecutive writes 0x11..0x14, one IDLE gap, then a new burst to requester 0.
REQ-031 Round-robin: iv_req=4'b1111 continuously -> owner sequence 0,1,2,3,0, each owner receiving 4 writes separated by one-cycle gaps.
REQ-032 Full stall: i_fifo_full high for 3 cycles after the 2nd write of a burst -> no wr_en/ack for 3 cycles, then writes 3 and 4 complete, and the burst totals 4 words.
REQ-033 Early release: owner drops req after 2 acks -> IDLE the next edge with exactly 2 writes, then the next requester is granted.
REQ-034 Reset mid-burst: reset_n low during write 2 -> all outputs 0 within the same cycle; after release with iv_req=4'b1000, the grant goes to requester 3 after one IDLE cycle.
REQ-035 Scoreboard against the async_fifo read side: the per-requester data sequences read out SHALL match the sequences presented, with no loss under random full/request traffic for 10,000 cycles.
